mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single shared memory port between the IF-stage instruction fetch and the MEM-stage load/store path of the RV32IM pipeline. Accepts one request at a time, drives a stall-safe request/acknowledge transaction to the memory, returns read data to the winner and generates the per-stage stall signals the pipeline control consumes. Sits between the IF/MEM stages and the memory model/controller. Data accesses win, with an anti-starvation guard for fetch.

## Interface
Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced
- TIMEOUT, 255, cycles in BUSY without m_ack before the access is aborted

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- if_req  input  1  fetch request, held until if_ready
- if_addr  input  32  fetch address (word aligned)
- if_rdata  output  32  fetched instruction, valid while if_ready
- if_ready  output  1  one-cycle completion pulse for fetch
- d_req  input  1  load/store request, held until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data address
- d_wdata  input  32  store data
- d_wstrb  input  4  byte enables for stores
- d_rdata  output  32  load data, valid while d_ready
- d_ready  output  1  one-cycle completion pulse for data
- m_req  output  1  memory request, held stable until m_ack
- m_we, m_addr, m_wdata, m_wstrb  output  1/32/32/4  memory command, stable while m_req
- m_rdata  input  32  memory read data, sampled with m_ack
- m_ack  input  1  memory completion, meaningful only while m_req
- stall_if  output  1  if_req & ~if_ready (combinational)
- stall_mem  output  1  d_req & ~d_ready (combinational)
- err  output  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if d_req and (streak < MAX_D_STREAK or ~if_req) -> grant data; else if if_req -> grant fetch; else stay. On grant register command (m_we = d_we for data, 0 for fetch; m_wstrb = 0 for fetch and loads), set m_req, go BUSY.
- Streak counter: increments on each data grant while if_req is high; clears on fetch grant or when if_req low at grant time. Saturates at MAX_D_STREAK.
- BUSY: m_req and command held constant. On m_ack: latch m_rdata into if_rdata or d_rdata (per grant), drop m_req, go RESP.
- RESP: pulse the granted port's ready for exactly one cycle, go IDLE. Requester deasserts req after seeing ready; re-arbitration happens only in IDLE, so a req still high in RESP is not double-served.
- Stores: d_rdata loaded with m_rdata regardless; software ignores it.
- Timeout: BUSY cycle counter; when it reaches TIMEOUT without m_ack, drop m_req, set err, go RESP with rdata = 32'h0000_0013 (fetch) or 32'h0 (data). err cleared only by reset.
- m_ack outside BUSY is ignored.

## Timing
- Reset (sync, active-high): state IDLE; m_req, m_we, m_wstrb, if_ready, d_ready, err = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; streak and timeout counters = 0. Reset mid-transaction: m_req low the cycle after the reset edge, no ready pulse issued.
- Latency: req sampled at edge t -> m_req high from t+1; m_ack high during cycle t+k -> ready high in cycle t+k+1. Minimum 3 cycles per access (ack in first BUSY cycle); back-to-back accesses therefore start every 3 cycles minimum.
- Simultaneous if_req and d_req in IDLE: data wins unless streak = MAX_D_STREAK.
- m_ack in the same cycle the timeout expires: ack wins, err not set.
- Timeout expires exactly TIMEOUT cycles after entering BUSY.

## Test plan
- Single fetch, memory acks 1 cycle after m_req: if_addr=0x100 -> m_req at t+1, m_addr=0x100, m_we=0; if_ready one cycle at t+2 with if_rdata = m_rdata; stall_if high t..t+1.
- Simultaneous requests: if_req and d_req (store 0x2000, wstrb 4'b0011) at same edge -> store served first, m_we=1, then fetch starts from next IDLE.
- Starvation: d_req held continuously for 10 accesses with if_req high -> after 4 data grants the 5th grant goes to fetch, then streak restarts.
- Slow memory: m_ack delayed 7 cycles -> m_req and command stable all 7 cycles; d_ready one cycle after ack; d_rdata = m_rdata.
- Timeout with TIMEOUT=8: no m_ack -> m_req drops after 8 BUSY cycles, err=1 sticky, if_ready pulses with if_rdata=0x00000013.
- Reset asserted in BUSY cycle 3 -> next cycle m_req=0, state IDLE, no ready pulse, err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between IF fetch and MEM load/store
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [SW-1:0] c_STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] c_TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [31:0]   c_NOP        = 32'h0000_0013;

    logic [1:0]    r_state;
    logic          r_gnt_d;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_tcnt;
    logic          r_m_req;
    logic          r_m_we;
    logic [31:0]   r_m_addr;
    logic [31:0]   r_m_wdata;
    logic [3:0]    r_m_wstrb;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic          r_if_ready;
    logic          r_d_ready;
    logic          r_err;

    logic          w_grant_d;

    // Data normally wins; fetch is forced once the data streak saturates.
    assign w_grant_d = d_req & ((r_streak < c_STREAK_MAX) | ~if_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_gnt_d    <= 1'b0;
            r_streak   <= '0;
            r_tcnt     <= '0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= 32'h0;
            r_m_wdata  <= 32'h0;
            r_m_wstrb  <= 4'h0;
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tcnt <= '0;
                    if (w_grant_d) begin
                        r_gnt_d   <= 1'b1;
                        r_m_req   <= 1'b1;
                        r_m_we    <= d_we;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        r_m_wstrb <= d_we ? d_wstrb : 4'h0;
                        r_state   <= c_BUSY;
                        if (!if_req)
                            r_streak <= '0;
                        else if (r_streak != c_STREAK_MAX)
                            r_streak <= r_streak + SW'(1);
                    end else if (if_req) begin
                        r_gnt_d   <= 1'b0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= if_addr;
                        r_m_wdata <= 32'h0;
                        r_m_wstrb <= 4'h0;
                        r_streak  <= '0;
                        r_state   <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    // An ack on the expiry cycle takes precedence over the abort.
                    if (m_ack) begin
                        r_m_req <= 1'b0;
                        if (r_gnt_d)
                            r_d_rdata <= m_rdata;
                        else
                            r_if_rdata <= m_rdata;
                        r_d_ready  <= r_gnt_d;
                        r_if_ready <= ~r_gnt_d;
                        r_state    <= c_RESP;
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_m_req <= 1'b0;
                        r_err   <= 1'b1;
                        if (r_gnt_d)
                            r_d_rdata <= 32'h0;
                        else
                            r_if_rdata <= c_NOP;
                        r_d_ready  <= r_gnt_d;
                        r_if_ready <= ~r_gnt_d;
                        r_state    <= c_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign m_req     = r_m_req;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign err       = r_err;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = d_req & ~r_d_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int vecs = 0;
    int errs = 0;

    // Memory responder controls
    logic mem_en    = 1'b1;
    logic stray_ack = 1'b0;
    int   ack_delay = 0;
    int   rsp_cnt   = 0;

    mem_port_arbiter #(
        .MAX_D_STREAK (4),
        .TIMEOUT      (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr ^ 0xDEAD0000, acking after ack_delay cycles of m_req.
    always @(negedge clk) begin
        if (m_req) begin
            if (mem_en && rsp_cnt == ack_delay) begin
                m_ack   = 1'b1;
                m_rdata = m_addr ^ 32'hDEAD_0000;
            end else begin
                m_ack   = 1'b0;
                m_rdata = 32'h0;
            end
            rsp_cnt = rsp_cnt + 1;
        end else begin
            m_ack   = stray_ack;
            m_rdata = stray_ack ? 32'hBAD0_BAD0 : 32'h0;
            rsp_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vecs++; if (m_req !== 1'b0) begin errs++; $display("FAIL rst_mreq got=%h exp=0", m_req); end
        vecs++; if ({if_ready, d_ready, err} !== 3'b000) begin errs++; $display("FAIL rst_ready_err got=%b exp=000", {if_ready, d_ready, err}); end
        vecs++; if ({m_we, m_wstrb} !== 5'h0) begin errs++; $display("FAIL rst_we_wstrb got=%h exp=0", {m_we, m_wstrb}); end
        vecs++; if ({m_addr, m_wdata} !== 64'h0) begin errs++; $display("FAIL rst_addr_wdata got=%h exp=0", {m_addr, m_wdata}); end
        vecs++; if ({if_rdata, d_rdata} !== 64'h0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", {if_rdata, d_rdata}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        #1;
        vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL sf_stall_t got=%h exp=1", stall_if); end
        tick();
        vecs++; if (m_req !== 1'b1) begin errs++; $display("FAIL sf_mreq got=%h exp=1", m_req); end
        vecs++; if (m_addr !== 32'h0000_0100) begin errs++; $display("FAIL sf_maddr got=%h exp=00000100", m_addr); end
        vecs++; if (m_we !== 1'b0) begin errs++; $display("FAIL sf_mwe got=%h exp=0", m_we); end
        vecs++; if ({stall_if, if_ready} !== 2'b10) begin errs++; $display("FAIL sf_stall_t1 got=%b exp=10", {stall_if, if_ready}); end
        tick();
        vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL sf_ready got=%h exp=1", if_ready); end
        vecs++; if (if_rdata !== 32'hDEAD_0100) begin errs++; $display("FAIL sf_rdata got=%h exp=dead0100", if_rdata); end
        vecs++; if ({m_req, stall_if} !== 2'b00) begin errs++; $display("FAIL sf_drop got=%b exp=00", {m_req, stall_if}); end
        if_req = 1'b0;
        tick();
        vecs++; if (if_ready !== 1'b0) begin errs++; $display("FAIL sf_pulse got=%h exp=0", if_ready); end
    endtask

    task automatic test_simultaneous();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'h1234_5678;
        d_wstrb = 4'b0011;
        tick();
        vecs++; if ({m_req, m_we} !== 2'b11) begin errs++; $display("FAIL sim_store_cmd got=%b exp=11", {m_req, m_we}); end
        vecs++; if (m_addr !== 32'h0000_2000) begin errs++; $display("FAIL sim_store_addr got=%h exp=00002000", m_addr); end
        vecs++; if ({m_wdata, m_wstrb} !== {32'h1234_5678, 4'b0011}) begin errs++; $display("FAIL sim_store_data got=%h exp=123456783", {m_wdata, m_wstrb}); end
        vecs++; if (stall_mem !== 1'b1) begin errs++; $display("FAIL sim_stall_mem got=%h exp=1", stall_mem); end
        tick();
        vecs++; if ({d_ready, if_ready} !== 2'b10) begin errs++; $display("FAIL sim_dready got=%b exp=10", {d_ready, if_ready}); end
        vecs++; if (d_rdata !== 32'hDEAD_2000) begin errs++; $display("FAIL sim_drdata got=%h exp=dead2000", d_rdata); end
        vecs++; if ({stall_if, stall_mem} !== 2'b10) begin errs++; $display("FAIL sim_stalls got=%b exp=10", {stall_if, stall_mem}); end
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        vecs++; if (m_req !== 1'b0) begin errs++; $display("FAIL sim_resp_idle got=%h exp=0", m_req); end
        tick();
        vecs++; if ({m_req, m_we, m_wstrb} !== 6'b100000) begin errs++; $display("FAIL sim_fetch_cmd got=%b exp=100000", {m_req, m_we, m_wstrb}); end
        vecs++; if (m_addr !== 32'h0000_0100) begin errs++; $display("FAIL sim_fetch_addr got=%h exp=00000100", m_addr); end
        tick();
        vecs++; if ({if_ready, if_rdata} !== {1'b1, 32'hDEAD_0100}) begin errs++; $display("FAIL sim_fetch_done got=%h exp=1dead0100", {if_ready, if_rdata}); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic        exp_fetch;
        logic [31:0] exp_addr;
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_3000;
        d_wstrb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            exp_fetch = ((i % 5) == 4);
            exp_addr  = exp_fetch ? 32'h0000_0200 : 32'h0000_3000;
            tick();
            vecs++; if ({m_req, m_addr} !== {1'b1, exp_addr}) begin errs++; $display("FAIL starve_grant%0d got=%h exp=%h", i, {m_req, m_addr}, {1'b1, exp_addr}); end
            tick();
            vecs++; if ({if_ready, d_ready} !== {exp_fetch, ~exp_fetch}) begin errs++; $display("FAIL starve_ready%0d got=%b exp=%b", i, {if_ready, d_ready}, {exp_fetch, ~exp_fetch}); end
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        vecs++; if (m_req !== 1'b0) begin errs++; $display("FAIL starve_end got=%h exp=0", m_req); end
    endtask

    task automatic test_slow_memory();
        ack_delay = 7;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_4000;
        d_wstrb = 4'hF;
        tick();
        vecs++; if ({m_req, m_we, m_wstrb} !== 6'b100000) begin errs++; $display("FAIL slow_cmd got=%b exp=100000", {m_req, m_we, m_wstrb}); end
        for (int k = 0; k < 7; k++) begin
            tick();
            vecs++; if ({m_req, m_addr, d_ready} !== {1'b1, 32'h0000_4000, 1'b0}) begin errs++; $display("FAIL slow_hold%0d got=%h exp=%h", k, {m_req, m_addr, d_ready}, {1'b1, 32'h0000_4000, 1'b0}); end
        end
        tick();
        vecs++; if ({d_ready, m_req} !== 2'b10) begin errs++; $display("FAIL slow_ready got=%b exp=10", {d_ready, m_req}); end
        vecs++; if (d_rdata !== 32'hDEAD_4000) begin errs++; $display("FAIL slow_rdata got=%h exp=dead4000", d_rdata); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL slow_ack_wins got=%h exp=0", err); end
        d_req     = 1'b0;
        ack_delay = 0;
        tick();
        vecs++; if (d_ready !== 1'b0) begin errs++; $display("FAIL slow_pulse got=%h exp=0", d_ready); end
    endtask

    task automatic test_timeout();
        mem_en  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            vecs++; if ({m_req, if_ready, err} !== 3'b100) begin errs++; $display("FAIL to_busy%0d got=%b exp=100", k, {m_req, if_ready, err}); end
        end
        tick();
        vecs++; if ({m_req, if_ready} !== 2'b01) begin errs++; $display("FAIL to_expire got=%b exp=01", {m_req, if_ready}); end
        vecs++; if (if_rdata !== 32'h0000_0013) begin errs++; $display("FAIL to_nop got=%h exp=00000013", if_rdata); end
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL to_err got=%h exp=1", err); end
        if_req = 1'b0;
        mem_en = 1'b1;
        tick();
        vecs++; if ({if_ready, err} !== 2'b01) begin errs++; $display("FAIL to_sticky got=%b exp=01", {if_ready, err}); end
        if_req  = 1'b1;
        if_addr = 32'h0000_0104;
        tick();
        tick();
        vecs++; if ({if_ready, if_rdata, err} !== {1'b1, 32'hDEAD_0104, 1'b1}) begin errs++; $display("FAIL to_after got=%h exp=%h", {if_ready, if_rdata, err}, {1'b1, 32'hDEAD_0104, 1'b1}); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        stray_ack = 1'b1;
        tick();
        tick();
        vecs++; if ({m_req, if_ready, d_ready} !== 3'b000) begin errs++; $display("FAIL stray_ack got=%b exp=000", {m_req, if_ready, d_ready}); end
        stray_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        mem_en  = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_6000;
        d_wdata = 32'hCAFE_F00D;
        d_wstrb = 4'hF;
        tick();
        tick();
        tick();
        vecs++; if (m_req !== 1'b1) begin errs++; $display("FAIL rb_busy got=%h exp=1", m_req); end
        reset = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        vecs++; if ({m_req, d_ready, err} !== 3'b000) begin errs++; $display("FAIL rb_reset got=%b exp=000", {m_req, d_ready, err}); end
        vecs++; if (m_addr !== 32'h0) begin errs++; $display("FAIL rb_addr got=%h exp=0", m_addr); end
        reset  = 1'b0;
        mem_en = 1'b1;
        tick();
        vecs++; if ({m_req, d_ready, if_ready} !== 3'b000) begin errs++; $display("FAIL rb_no_pulse got=%b exp=000", {m_req, d_ready, if_ready}); end
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        m_ack   = 1'b0;
        m_rdata = 32'h0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_slow_memory();
        test_timeout();
        test_stray_ack();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
